// File: rtl/btn_ce_gen.sv
// Button conditioning and display pacing: sync + debounce + press/auto-repeat strobe, plus display CE divider.
// Latency: clean level change reaches BTN_STATE/BTN_CE after DEBOUNCE_CYCLES+2 edges; DISP_CE every DISP_DIV edges.
// Backpressure: none; strobes are single-cycle pulses with no handshake, the consumer must sample every cycle.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset, clears every flop
//   BTN_IN     raw asynchronous button level (active-high)
//   REPEAT_EN  synchronous auto-repeat enable
//   BTN_CE     one-clock press / auto-repeat strobe
//   BTN_STATE  debounced button level
//   DISP_CE    one-clock display refresh strobe
module btn_ce_gen #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int DISP_DIV        = 100000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_IN,
  input  logic REPEAT_EN,
  output logic BTN_CE,
  output logic BTN_STATE,
  output logic DISP_CE
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int DISP_W  = $clog2(DISP_DIV);

  localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]  REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [DISP_W-1:0] DISP_LAST    = DISP_W'(DISP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } fsm_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; only sync2_q is used downstream.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= BTN_IN;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the synced level must disagree with the accepted level for
  // DEBOUNCE_CYCLES consecutive edges before it is accepted.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] cnt_db_q, cnt_db_d;
  logic            state_q, state_d;

  always_comb begin
    cnt_db_d = '0;
    state_d  = state_q;
    if (sync2_q != state_q) begin
      if (cnt_db_q == DB_LAST) begin
        state_d = ~state_q;
      end else begin
        cnt_db_d = cnt_db_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_db_q <= '0;
      state_q  <= 1'b0;
    end else begin
      cnt_db_q <= cnt_db_d;
      state_q  <= state_d;
    end
  end

  // The FSM reacts to the level change in the same edge it is accepted, so it
  // looks at the next-state value rather than the registered one.
  logic press_w, release_w;
  assign press_w   =  state_d & ~state_q;
  assign release_w = ~state_d &  state_q;

  // ---------------------------------------------------------------------------
  // Press / auto-repeat FSM with registered strobe.
  // ---------------------------------------------------------------------------
  fsm_t             fsm_q;
  logic [REP_W-1:0] cnt_rep_q;
  logic             btn_ce_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q     <= IDLE;
      cnt_rep_q <= '0;
      btn_ce_q  <= 1'b0;
    end else begin
      btn_ce_q <= 1'b0;
      if (release_w) begin
        fsm_q     <= IDLE;
        cnt_rep_q <= '0;
      end else begin
        case (fsm_q)
          IDLE: begin
            if (press_w) begin
              btn_ce_q  <= 1'b1;
              cnt_rep_q <= '0;
              fsm_q     <= HELD_DELAY;
            end
          end
          HELD_DELAY: begin
            if (!REPEAT_EN) begin
              cnt_rep_q <= '0;
            end else if (cnt_rep_q == REP_DLY_LAST) begin
              // With a one-cycle delay the terminal count could land right
              // after the press strobe; hold at terminal so strobes never abut.
              if (!btn_ce_q) begin
                btn_ce_q  <= 1'b1;
                cnt_rep_q <= '0;
                fsm_q     <= HELD_REPEAT;
              end
            end else begin
              cnt_rep_q <= cnt_rep_q + 1'b1;
            end
          end
          HELD_REPEAT: begin
            if (!REPEAT_EN) begin
              cnt_rep_q <= '0;
              fsm_q     <= HELD_DELAY;
            end else if (cnt_rep_q == REP_PER_LAST) begin
              if (!btn_ce_q) begin
                btn_ce_q  <= 1'b1;
                cnt_rep_q <= '0;
              end
            end else begin
              cnt_rep_q <= cnt_rep_q + 1'b1;
            end
          end
          default: begin
            fsm_q     <= IDLE;
            cnt_rep_q <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running display divider; strobe is registered off the wrap point.
  // ---------------------------------------------------------------------------
  logic [DISP_W-1:0] cnt_disp_q;
  logic              disp_ce_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_disp_q <= '0;
      disp_ce_q  <= 1'b0;
    end else begin
      disp_ce_q <= (cnt_disp_q == DISP_LAST);
      if (cnt_disp_q == DISP_LAST) begin
        cnt_disp_q <= '0;
      end else begin
        cnt_disp_q <= cnt_disp_q + 1'b1;
      end
    end
  end

  assign BTN_CE    = btn_ce_q;
  assign BTN_STATE = state_q;
  assign DISP_CE   = disp_ce_q;

endmodule

// File: tb/tb_btn_ce_gen.sv
// Directed bench for btn_ce_gen with small parameters; expected strobe/level
// edges are queued per scenario and consumed as the edge counter reaches them.
module tb_btn_ce_gen;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int DD = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BTN_IN = 1'b0;
  logic REPEAT_EN = 1'b0;
  logic BTN_CE, BTN_STATE, DISP_CE;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int ce_q[$];
  int st_q[$];
  int disp_q[$];
  logic exp_state = 1'b0;

  btn_ce_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .DISP_DIV       (DD)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_IN   (BTN_IN),
    .REPEAT_EN(REPEAT_EN),
    .BTN_CE   (BTN_CE),
    .BTN_STATE(BTN_STATE),
    .DISP_CE  (DISP_CE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  // One rising edge, then compare all outputs against the scoreboard.
  task automatic tick();
    logic exp_ce, exp_disp;
    @(posedge CLK);
    #1;
    edge_n++;
    exp_ce = 1'b0;
    exp_disp = 1'b0;
    if (ce_q.size() > 0 && ce_q[0] == edge_n) begin
      exp_ce = 1'b1;
      void'(ce_q.pop_front());
    end
    if (disp_q.size() > 0 && disp_q[0] == edge_n) begin
      exp_disp = 1'b1;
      void'(disp_q.pop_front());
    end
    if (st_q.size() > 0 && st_q[0] == edge_n) begin
      exp_state = ~exp_state;
      void'(st_q.pop_front());
    end
    chk("btn_ce", BTN_CE, exp_ce);
    chk("btn_state", BTN_STATE, exp_state);
    chk("disp_ce", DISP_CE, exp_disp);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Assert reset mid-cycle (outputs must clear immediately), then release it
  // so that the next rising edge is edge 1.
  task automatic start_scenario(input logic btn, input logic ren);
    RST = 1'b1;
    BTN_IN = btn;
    REPEAT_EN = ren;
    #1;
    chk("rst_btn_ce", BTN_CE, 1'b0);
    chk("rst_btn_state", BTN_STATE, 1'b0);
    chk("rst_disp_ce", DISP_CE, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    edge_n = 0;
    exp_state = 1'b0;
    ce_q.delete();
    st_q.delete();
    disp_q.delete();
    for (int k = DD; k <= 400; k += DD) disp_q.push_back(k);
  endtask

  task automatic end_scenario(input string name);
    chk_n({name, "_ce_left"}, ce_q.size(), 0);
    chk_n({name, "_st_left"}, st_q.size(), 0);
  endtask

  initial begin
    // 1: idle button, only the display strobe runs.
    start_scenario(1'b0, 1'b0);
    run(30);
    end_scenario("idle");

    // 2: clean press, no repeat.
    start_scenario(1'b1, 1'b0);
    ce_q.push_back(6);
    st_q.push_back(6);
    run(40);
    end_scenario("press");

    // 3: bounce 1,1,1,0 for 20 edges, then steady 1 from edge 21.
    start_scenario(1'b1, 1'b0);
    ce_q.push_back(26);
    st_q.push_back(26);
    for (int e = 1; e <= 40; e++) begin
      BTN_IN = (e <= 20 && (e % 4) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    end_scenario("bounce");

    // 4a: continuous auto-repeat.
    start_scenario(1'b1, 1'b1);
    ce_q.push_back(6);
    ce_q.push_back(16);
    ce_q.push_back(21);
    ce_q.push_back(26);
    ce_q.push_back(31);
    st_q.push_back(6);
    run(34);
    end_scenario("repeat");

    // 4b: REPEAT_EN low from edge 23, restored at edge 30 (delay restarts).
    start_scenario(1'b1, 1'b1);
    ce_q.push_back(6);
    ce_q.push_back(16);
    ce_q.push_back(21);
    ce_q.push_back(39);
    ce_q.push_back(44);
    st_q.push_back(6);
    for (int e = 1; e <= 46; e++) begin
      REPEAT_EN = (e < 23 || e >= 30) ? 1'b1 : 1'b0;
      tick();
    end
    end_scenario("repeat_drop");

    // 5: 3-edge release glitch ignored, real release at 31, re-press at 45.
    start_scenario(1'b1, 1'b0);
    ce_q.push_back(6);
    ce_q.push_back(50);
    st_q.push_back(6);
    st_q.push_back(36);
    st_q.push_back(50);
    for (int e = 1; e <= 60; e++) begin
      BTN_IN = ((e >= 20 && e <= 22) || (e >= 31 && e < 45)) ? 1'b0 : 1'b1;
      tick();
    end
    end_scenario("release");

    // 6: reset while held; button stays down and is re-debounced.
    start_scenario(1'b1, 1'b0);
    ce_q.push_back(6);
    st_q.push_back(6);
    run(8);
    end_scenario("pre_rst");
    start_scenario(1'b1, 1'b0);
    ce_q.push_back(6);
    st_q.push_back(6);
    run(20);
    end_scenario("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d observed=timeout expected=finish", edge_n);
    $fatal(1, "watchdog expired");
  end

endmodule
